// File: rtl/word_packer_pkg.sv
// word_packer shared constants and helpers.
// Default geometry and overflow counter width.
package word_packer_pkg;

  localparam int WP_M_DEF     = 2;
  localparam int WP_DEPTH_DEF = 4;
  localparam int OVFCNT_W     = 8;

  function automatic int lvl_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/word_packer_if.sv
// word_packer bus: serial in, word out, status.
// master drives stream/ready/flush; slave is the packer.
interface word_packer_if
  import word_packer_pkg::*;
#(
  parameter int M     = WP_M_DEF,
  parameter int DEPTH = WP_DEPTH_DEF
);

  localparam int LW = lvl_w(DEPTH);

  logic          sin_valid;
  logic          sin_data;
  logic          flush;
  logic          word_valid;
  logic          word_ready;
  logic [M-1:0]  word_data;
  logic          full;
  logic          empty;
  logic [LW-1:0] level;
  logic          overflow;
`ifdef WORD_PACKER_OVFCNT_EN
  logic [OVFCNT_W-1:0] ovf_count;

  modport master (
    output sin_valid, sin_data, flush, word_ready,
    input  word_valid, word_data, full, empty,
    input  level, overflow, ovf_count
  );

  modport slave (
    input  sin_valid, sin_data, flush, word_ready,
    output word_valid, word_data, full, empty,
    output level, overflow, ovf_count
  );
`else
  modport master (
    output sin_valid, sin_data, flush, word_ready,
    input  word_valid, word_data, full, empty,
    input  level, overflow
  );

  modport slave (
    input  sin_valid, sin_data, flush, word_ready,
    output word_valid, word_data, full, empty,
    output level, overflow
  );
`endif

endinterface

// File: rtl/word_packer_fifo.sv
// FWFT word FIFO: i_push/i_pop/i_flush, i_wdata in;
// o_rdata (head), o_full, o_empty, o_level out.
module word_packer_fifo
  import word_packer_pkg::*;
#(
  parameter int M     = WP_M_DEF,
  parameter int DEPTH = WP_DEPTH_DEF
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    i_push,
  input  logic                    i_pop,
  input  logic                    i_flush,
  input  logic [M-1:0]            i_wdata,
  output logic [M-1:0]            o_rdata,
  output logic                    o_full,
  output logic                    o_empty,
  output logic [lvl_w(DEPTH)-1:0] o_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = lvl_w(DEPTH);

  logic [M-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [LW-1:0] r_level;
  logic          w_pop;
  logic          w_push;

  assign o_empty = (r_level == '0);
  assign o_full  = (r_level == LW'(DEPTH));
  assign o_level = r_level;
  assign o_rdata = r_mem[r_rd];

  // a pop frees a slot, so a full FIFO can still take a push
  assign w_pop  = i_pop && !o_empty;
  assign w_push = i_push && (!o_full || w_pop);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr    <= '0;
      r_rd    <= '0;
      r_level <= '0;
    end else if (i_flush) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_level <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= i_wdata;
        r_wr        <= r_wr + 1'b1;
      end
      if (w_pop) r_rd <= r_rd + 1'b1;
      if (w_push && !w_pop) r_level <= r_level + 1'b1;
      else if (w_pop && !w_push) r_level <= r_level - 1'b1;
    end
  end

endmodule

// File: rtl/word_packer.sv
// word_packer: packs LSB-first serial bits into M-bit words in a FIFO.
// Ports: clock, reset_n, bus (slave). Option: WORD_PACKER_OVFCNT_EN.
module word_packer
  import word_packer_pkg::*;
#(
  parameter int M     = WP_M_DEF,
  parameter int DEPTH = WP_DEPTH_DEF
) (
  input  logic         clock,
  input  logic         reset_n,
  word_packer_if.slave bus
);

  localparam int BW = $clog2(M);
  localparam int LW = lvl_w(DEPTH);

  logic [BW-1:0] r_bcnt;
  logic [M-1:0]  r_sreg;
  logic          r_overflow;
  logic [M-1:0]  w_word;
  logic          w_last;
  logic          w_full;
  logic          w_empty;
  logic          w_drop;
  logic [LW-1:0] w_level;

  // current bit merged in; equals the finished word on the last bit
  always_comb begin
    w_word         = r_sreg;
    w_word[r_bcnt] = bus.sin_data;
  end

  assign w_last = bus.sin_valid && (r_bcnt == BW'(M - 1));
  assign w_drop = w_last && w_full && !(bus.word_ready && !w_empty);

  word_packer_fifo #(
    .M     (M),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .i_push  (w_last),
    .i_pop   (bus.word_ready),
    .i_flush (bus.flush),
    .i_wdata (w_word),
    .o_rdata (bus.word_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (w_level)
  );

  assign bus.word_valid = !w_empty;
  assign bus.full       = w_full;
  assign bus.empty      = w_empty;
  assign bus.level      = w_level;
  assign bus.overflow   = r_overflow;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_bcnt     <= '0;
      r_sreg     <= '0;
      r_overflow <= 1'b0;
    end else if (bus.flush) begin
      r_bcnt     <= '0;
      r_sreg     <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= w_drop;
      if (bus.sin_valid) begin
        if (w_last) begin
          r_bcnt <= '0;
          r_sreg <= '0;
        end else begin
          r_bcnt <= r_bcnt + 1'b1;
          r_sreg <= w_word;
        end
      end
    end
  end

`ifdef WORD_PACKER_OVFCNT_EN
  logic [OVFCNT_W-1:0] r_ovf_cnt;

  assign bus.ovf_count = r_ovf_cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_ovf_cnt <= '0;
    end else if (bus.flush) begin
      r_ovf_cnt <= '0;
    end else if (w_drop && (r_ovf_cnt != '1)) begin
      r_ovf_cnt <= r_ovf_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_word_packer.sv
// word_packer bench: directed vectors, M=2/DEPTH=4 and M=3/DEPTH=4.
// Expected values are hand-computed constants.
module tb_word_packer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  word_packer_if #(.M(2), .DEPTH(4)) ia ();
  word_packer_if #(.M(3), .DEPTH(4)) ib ();

  word_packer #(.M(2), .DEPTH(4)) u_a (
    .clock   (clk),
    .reset_n (rst_n),
    .bus     (ia)
  );

  word_packer #(.M(3), .DEPTH(4)) u_b (
    .clock   (clk),
    .reset_n (rst_n),
    .bus     (ib)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bit_a(input logic b);
    ia.sin_valid = 1'b1;
    ia.sin_data  = b;
    tick();
    ia.sin_valid = 1'b0;
    ia.sin_data  = 1'b0;
  endtask

  task automatic word_a(input logic [1:0] w);
    bit_a(w[0]);
    bit_a(w[1]);
  endtask

  task automatic pop_a(input string tag, input logic [1:0] exp);
    check(tag, ia.word_data, exp);
    ia.word_ready = 1'b1;
    tick();
    ia.word_ready = 1'b0;
  endtask

  logic [1:0] exp3 [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
  logic [1:0] exp4 [4] = '{2'd2, 2'd3, 2'd0, 2'd1};
  logic [2:0] tbl6 [10] = '{3'd5, 3'd2, 3'd7, 3'd0, 3'd3,
                            3'd6, 3'd1, 3'd4, 3'd5, 3'd3};

  initial begin
    ia.sin_valid  = 1'b0;
    ia.sin_data   = 1'b0;
    ia.flush      = 1'b0;
    ia.word_ready = 1'b0;
    ib.sin_valid  = 1'b0;
    ib.sin_data   = 1'b0;
    ib.flush      = 1'b0;
    ib.word_ready = 1'b0;

    #12;
    check("rst_valid", ia.word_valid, 0);
    check("rst_data", ia.word_data, 0);
    check("rst_empty", ia.empty, 1);
    check("rst_full", ia.full, 0);
    check("rst_level", ia.level, 0);
    check("rst_ovf", ia.overflow, 0);
    rst_n = 1'b1;
    tick();

    // single word 1,0 -> 01
    word_a(2'b01);
    check("one_data", ia.word_data, 1);
    check("one_valid", ia.word_valid, 1);
    check("one_level", ia.level, 1);
    pop_a("one_pop", 2'b01);
    check("one_empty", ia.empty, 1);

    // fill and overflow
    word_a(2'b01);
    word_a(2'b10);
    word_a(2'b11);
    word_a(2'b00);
    check("fill_full", ia.full, 1);
    check("fill_level", ia.level, 4);
    check("fill_noovf", ia.overflow, 0);
    word_a(2'b11);
    check("ovf_pulse", ia.overflow, 1);
    check("ovf_level", ia.level, 4);
    tick();
    check("ovf_end", ia.overflow, 0);
`ifdef WORD_PACKER_OVFCNT_EN
    check("ovf_count", ia.ovf_count, 1);
`endif
    for (int i = 0; i < 4; i++) pop_a("ovf_order", exp3[i]);
    check("ovf_empty", ia.empty, 1);

    // push and pop on the same edge while full
    word_a(2'b01);
    word_a(2'b10);
    word_a(2'b11);
    word_a(2'b00);
    check("pp_level0", ia.level, 4);
    bit_a(1'b1);
    ia.word_ready = 1'b1;
    bit_a(1'b0);
    ia.word_ready = 1'b0;
    check("pp_level", ia.level, 4);
    check("pp_noovf", ia.overflow, 0);
    for (int i = 0; i < 4; i++) pop_a("pp_order", exp4[i]);
    check("pp_empty", ia.empty, 1);

    // flush mid-word, with a stored word present
    word_a(2'b10);
    bit_a(1'b1);
    ia.flush = 1'b1;
    tick();
    ia.flush = 1'b0;
    check("fl_level", ia.level, 0);
    check("fl_empty", ia.empty, 1);
`ifdef WORD_PACKER_OVFCNT_EN
    check("fl_ovfcnt", ia.ovf_count, 0);
`endif
    word_a(2'b11);
    check("fl_data11", ia.word_data, 3);
    check("fl_level1", ia.level, 1);
    pop_a("fl_pop11", 2'b11);
    bit_a(1'b1);
    ia.flush = 1'b1;
    tick();
    ia.flush = 1'b0;
    word_a(2'b10);
    check("fl_data10", ia.word_data, 2);
    check("fl_level2", ia.level, 1);
    pop_a("fl_pop10", 2'b10);

    // asynchronous reset mid-word and mid-transfer
    word_a(2'b01);
    bit_a(1'b1);
    #3;
    rst_n = 1'b0;
    #1;
    check("ar_valid", ia.word_valid, 0);
    check("ar_data", ia.word_data, 0);
    check("ar_level", ia.level, 0);
    check("ar_empty", ia.empty, 1);
    check("ar_ovf", ia.overflow, 0);
    rst_n = 1'b1;
    word_a(2'b10);
    check("ar_after", ia.word_data, 2);
    check("ar_lvl", ia.level, 1);

    // M=3: gapped stream, continuous pop, pointer wrap
    ib.word_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      for (int b = 0; b < 3; b++) begin
        ib.sin_valid = 1'b1;
        ib.sin_data  = tbl6[i][b];
        tick();
        ib.sin_valid = 1'b0;
        ib.sin_data  = 1'b0;
        if (b == 2) begin
          check("g_valid", ib.word_valid, 1);
          check("g_data", ib.word_data, tbl6[i]);
          check("g_ovf", ib.overflow, 0);
        end
        tick();
      end
    end
    check("g_empty", ib.empty, 1);
    check("g_ovf_end", ib.overflow, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/word_packer.md
# word_packer

Serial-to-parallel front end that collects a 1-bit stream into M-bit words and buffers them in a DEPTH-entry first-word-fall-through FIFO. It sits directly upstream of the M-bit word consumers in the test-module set: its `word_data` drives their `d` input. Storage is an unpacked array declared by size (`[DEPTH]`), so this block also serves as a TMRG triplication test case for size-declared unpacked arrays in sequential logic.

## Interface
- `M`, 2: word width in bits; legal values are 2 or more.
- `DEPTH`, 4: FIFO entries; must be a power of two, 2 or more.

Ports:
- `clock`  in  1  single clock; all state changes on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `sin_valid`  in  1  `sin_data` is sampled on this edge.
- `sin_data`  in  1  serial bit; LSB-first.
- `flush`  in  1  synchronous clear of the partial word and the FIFO.
- `word_valid`  out  1  FIFO non-empty; equal to `!empty`.
- `word_ready`  in  1  consumer accepts the head word.
- `word_data`  out  M  head word (`mem[rd_ptr]`).
- `full`  out  1  FIFO holds DEPTH words.
- `empty`  out  1  FIFO holds 0 words.
- `level`  out  $clog2(DEPTH)+1  number of stored words.
- `overflow`  out  1  one-cycle pulse when a completed word is dropped.

## Operation
**Assembly**
- A bit counter `bcnt` (0..M-1) and a shift register `sreg[M-1:0]` assemble each word.
- On an edge with `sin_valid=1`, `sin_data` is written to bit `bcnt`, so the first bit received lands in bit 0.
- When `bcnt==M-1`, the word is complete: the completed word is `{sin_data, sreg[M-2:0]}` and `bcnt` wraps to 0.
- Edges with `sin_valid=0` leave `bcnt` and `sreg` unchanged, so gaps in the stream are allowed.

**Push and pop**
- A completed word is pushed to `mem[wr_ptr]` on the same edge it completes.
- Pop occurs on `word_valid && word_ready`: `rd_ptr` advances.
- Both pointers are $clog2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0.
- `level` changes by +1 on push only, -1 on pop only, and 0 on push and pop together.

**Boundary rules**
- **Full, push, no pop:** the word is dropped, `overflow`=1 for that cycle, `bcnt` still wraps to 0, and stored data is untouched.
- **Full, push and pop together:** both are accepted; `level` stays DEPTH and there is no overflow.
- **Empty, push:** the push is accepted; `word_ready` has no effect because `word_valid`=0.
- **`flush`=1:** overrides all activity that cycle. `bcnt`, `sreg`, both pointers and `level` go to 0, and any push or pop that cycle is discarded. `mem` contents are not cleared.
- **Reset mid-word or mid-transfer:** all state clears asynchronously and the partial word is lost.

**Reset values**
- `word_valid` 0, `word_data` 0 (all `mem` entries reset to 0), `full` 0, `empty` 1, `level` 0, `overflow` 0.

## Timing
- All outputs are registered or derived only from registers; there is no combinational path from any input to any output.
- Latency: if the last bit of a word is sampled at edge k and the FIFO was empty, `word_valid`=1 and `word_data` is valid after edge k.
- The next word is presented after the pop edge.
- `overflow` is high for exactly the cycle after the dropping edge.
- Throughput: one word every M `sin_valid` cycles, with no bubbles while the FIFO is not full.

## Configuration
- Macro: `WORD_PACKER_OVFCNT_EN`.
- **Defined:** adds an output `ovf_count` (out, 8 bits) that counts dropped words.
  - It increments on each `overflow` pulse and saturates at 255.
  - It is cleared by `reset_n` and by `flush`.
- **Undefined:** the port and its counter are absent. The `overflow` pulse behaves identically in both builds.

## Structure
- Package `word_packer_pkg`: default constants `WP_M_DEF`=2, `WP_DEPTH_DEF`=4, and `OVFCNT_W`=8.
- Sub-module `word_packer_fifo`:
  - Holds the `logic [M-1:0] mem [DEPTH]` array, the pointers, `level`, `full` and `empty`.
  - Has a push/pop/flush interface.
  - The top level keeps the assembler, overflow detection and the optional counter.

## Test plan
Use M=2, DEPTH=4 unless noted.
1. **Reset:** assert `reset_n`=0 mid-cycle → outputs clear immediately to `word_valid`=0, `word_data`=0, `empty`=1, `level`=0, `overflow`=0.
2. **Single word:** send `sin_data` 1 then 0 with `sin_valid`=1 → after the second edge `word_data`=2'b01, `word_valid`=1, `level`=1. Pop with `word_ready`=1 → `empty`=1 on the next cycle.
3. **Fill and overflow:** hold `word_ready`=0 and send words 01, 10, 11, 00 → `full`=1, `level`=4. Send a fifth word 11 → `overflow` pulses once, `level`=4, and pops return 01, 10, 11, 00 in order. With the macro defined, `ovf_count`=1.
4. **Push and pop while full:** with `level`=4, complete a word on the same edge as a pop → `level` stays 4, `overflow`=0, and FIFO order is preserved.
5. **Flush mid-word:** after one bit (1), assert `flush` → `level`=0 and `empty`=1. Then send 1, 1 → `word_data`=2'b11, confirming the partial word was discarded.
6. **Gapped stream and wrap-around:** with M=3 and `sin_valid` toggling every other cycle, push 10 words while popping continuously → all 10 words are returned in order, pointers wrap correctly, and `overflow` never asserts.
